// File: rtl/alu_muldiv.sv
// alu_muldiv: iterative shift-add multiplier / restoring divider with HI/LO registers
module alu_muldiv #(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             dbz,
    output logic             zero
);
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH:0]     acc_q, acc_d;
    logic [WIDTH-1:0]   ql_q, ql_d, m_q, m_d, hi_q, hi_d, lo_q, lo_d;
    logic               div_q, div_d, neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d;
    logic               busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag, quo, rem;
    logic [WIDTH:0]     msum, dsh;
    logic [WIDTH+1:0]   ddiff;
    logic [2*WIDTH-1:0] prod;
    always_comb begin
        a_neg    = op[0] & a[WIDTH-1];
        b_neg    = op[0] & b[WIDTH-1];
        a_mag    = a_neg ? -a : a;
        b_mag    = b_neg ? -b : b;
        msum     = {1'b0, acc_q[WIDTH-1:0]} + {1'b0, m_q & {WIDTH{ql_q[0]}}};
        dsh      = {acc_q[WIDTH-1:0], ql_q[WIDTH-1]};
        ddiff    = {1'b0, dsh} - {2'b0, m_q};
        prod     = neg_lo_q ? -{acc_q[WIDTH-1:0], ql_q} : {acc_q[WIDTH-1:0], ql_q};
        quo      = neg_lo_q ? -ql_q : ql_q;
        rem      = neg_hi_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        ql_d     = ql_q;
        m_d      = m_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        div_d    = div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        dbz_d    = dbz_q;
        if (state_q == IDLE) begin
            if (start && op[2:1] != 2'b11) begin
                dbz_d = 1'b0;
                if (op[2]) begin
                    hi_d   = op[0] ? hi_q : a;
                    lo_d   = op[0] ? a : lo_q;
                    done_d = 1'b1;
                end else begin
                    state_d  = RUN;
                    cnt_d    = CNT_W'(WIDTH);
                    busy_d   = 1'b1;
                    div_d    = op[1];
                    acc_d    = '0;
                    ql_d     = a_mag;
                    m_d      = b_mag;
                    neg_lo_d = a_neg ^ b_neg;
                    neg_hi_d = a_neg;
                end
            end
        end else if (state_q == RUN) begin
            cnt_d   = cnt_q - 1'b1;
            state_d = (cnt_q == CNT_W'(1)) ? FIX : RUN;
            // divide: keep the trial subtraction only when it does not borrow
            acc_d   = div_q ? (ddiff[WIDTH+1] ? dsh : ddiff[WIDTH:0]) : {1'b0, msum[WIDTH:1]};
            ql_d    = div_q ? {ql_q[WIDTH-2:0], ~ddiff[WIDTH+1]} : {msum[0], ql_q[WIDTH-1:1]};
        end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            if (div_q && m_q == '0) begin
                dbz_d = 1'b1;
            end else begin
                hi_d = div_q ? rem : prod[2*WIDTH-1:WIDTH];
                lo_d = div_q ? quo : prod[WIDTH-1:0];
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            ql_q     <= '0;
            m_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            div_q    <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            ql_q     <= ql_d;
            m_q      <= m_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            div_q    <= div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
        end
    end
    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
    assign dbz  = dbz_q;
    assign zero = (lo_q == '0);
endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: directed checks of alu_muldiv at WIDTH=32 and WIDTH=8
module tb_alu_muldiv;
    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = '0, b = '0;
    logic        busy, done, dbz, zero;
    logic [31:0] hi, lo;
    logic        start8 = 1'b0;
    logic [2:0]  op8 = 3'd0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8, dbz8, zero8;
    logic [7:0]  hi8, lo8;
    int          nchk = 0, nerr = 0;

    alu_muldiv #(.WIDTH(32)) u_dut (.clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .hi(hi), .lo(lo), .dbz(dbz), .zero(zero));
    alu_muldiv #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .start(start8), .op(op8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .hi(hi8), .lo(lo8), .dbz(dbz8), .zero(zero8));

    always #5 clk = ~clk;

    task automatic go(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0; a = 32'h5A5A_5A5A; b = 32'hA5A5_A5A5;
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk); #1;
            if (done) begin lat = n; break; end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; #12;
        nchk++; if ({busy, done, dbz, zero} !== 4'b0001) begin nerr++; $display("FAIL reset_flags: got %b want 0001", {busy, done, dbz, zero}); end
        nchk++; if ({hi, lo} !== 64'h0) begin nerr++; $display("FAIL reset_hilo: got %h want 0", {hi, lo}); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_multu;
        int bc = 0, lat = -1;
        go(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        start = 1'b1; op = 3'b100; a = 32'hDEAD_BEEF;
        bc = busy;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk); #1;
            if (done) begin lat = n; break; end
            bc += busy;
        end
        start = 1'b0;
        nchk++; if (lat !== 33) begin nerr++; $display("FAIL multu_latency: got %0d want 33", lat); end
        nchk++; if (bc !== 33) begin nerr++; $display("FAIL multu_busy_cycles: got %0d want 33", bc); end
        nchk++; if (hi !== 32'hFFFF_FFFE) begin nerr++; $display("FAIL multu_hi: got %h want fffffffe", hi); end
        nchk++; if (lo !== 32'h0000_0001) begin nerr++; $display("FAIL multu_lo: got %h want 00000001", lo); end
        nchk++; if (busy !== 1'b0) begin nerr++; $display("FAIL multu_busy_done: got %b want 0", busy); end
        @(posedge clk); #1;
        nchk++; if (done !== 1'b0) begin nerr++; $display("FAIL multu_done_pulse: got %b want 0", done); end
        nchk++; if (hi !== 32'hFFFF_FFFE) begin nerr++; $display("FAIL multu_hi_hold: got %h want fffffffe", hi); end
    endtask

    task automatic test_mult;
        int lat;
        go(3'b001, 32'hFFFF_FFFD, 32'd5);
        wait_done(lat);
        nchk++; if (lat !== 33) begin nerr++; $display("FAIL mult_latency: got %0d want 33", lat); end
        nchk++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFF1) begin nerr++; $display("FAIL mult_hilo: got %h want fffffffffffffff1", {hi, lo}); end
        nchk++; if (zero !== 1'b0) begin nerr++; $display("FAIL mult_zero: got %b want 0", zero); end
    endtask

    task automatic test_div;
        int lat;
        go(3'b011, 32'hFFFF_FFF9, 32'd2);
        wait_done(lat);
        nchk++; if (lo !== 32'hFFFF_FFFD) begin nerr++; $display("FAIL div_lo: got %h want fffffffd", lo); end
        nchk++; if (hi !== 32'hFFFF_FFFF) begin nerr++; $display("FAIL div_hi: got %h want ffffffff", hi); end
        go(3'b011, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(lat);
        nchk++; if (lat !== 33) begin nerr++; $display("FAIL div_ovf_latency: got %0d want 33", lat); end
        nchk++; if ({hi, lo} !== 64'h0000_0000_8000_0000) begin nerr++; $display("FAIL div_ovf_hilo: got %h want 0000000080000000", {hi, lo}); end
        nchk++; if (dbz !== 1'b0) begin nerr++; $display("FAIL div_ovf_dbz: got %b want 0", dbz); end
        go(3'b010, 32'd100, 32'd7);
        wait_done(lat);
        nchk++; if ({hi, lo} !== {32'd2, 32'd14}) begin nerr++; $display("FAIL divu_hilo: got %h want %h", {hi, lo}, {32'd2, 32'd14}); end
    endtask

    task automatic test_dbz;
        int lat;
        go(3'b100, 32'h1234, 32'h0);
        nchk++; if ({done, busy} !== 2'b10) begin nerr++; $display("FAIL mthi_handshake: got %b want 10", {done, busy}); end
        nchk++; if (hi !== 32'h1234) begin nerr++; $display("FAIL mthi_hi: got %h want 00001234", hi); end
        go(3'b101, 32'h0, 32'h0);
        nchk++; if ({done, busy, zero} !== 3'b101) begin nerr++; $display("FAIL mtlo_handshake: got %b want 101", {done, busy, zero}); end
        go(3'b010, 32'd100, 32'd0);
        wait_done(lat);
        nchk++; if (lat !== 33) begin nerr++; $display("FAIL dbz_latency: got %0d want 33", lat); end
        nchk++; if ({dbz, zero} !== 2'b11) begin nerr++; $display("FAIL dbz_flags: got %b want 11", {dbz, zero}); end
        nchk++; if ({hi, lo} !== 64'h0000_1234_0000_0000) begin nerr++; $display("FAIL dbz_hilo: got %h want 0000123400000000", {hi, lo}); end
        @(posedge clk); #1;
        nchk++; if (dbz !== 1'b1) begin nerr++; $display("FAIL dbz_sticky: got %b want 1", dbz); end
        go(3'b101, 32'd5, 32'd0);
        nchk++; if ({dbz, lo} !== {1'b0, 32'd5}) begin nerr++; $display("FAIL dbz_clear: got %h want %h", {dbz, lo}, {1'b0, 32'd5}); end
    endtask

    task automatic test_back_to_back;
        int lat;
        go(3'b110, 32'hFFFF_0000, 32'h1);
        nchk++; if ({done, busy, lo} !== {2'b00, 32'd5}) begin nerr++; $display("FAIL reserved_op: got %h want %h", {done, busy, lo}, {2'b00, 32'd5}); end
        go(3'b000, 32'd3, 32'd4);
        wait_done(lat);
        go(3'b000, 32'd6, 32'd7);
        nchk++; if ({done, busy, lo} !== {2'b01, 32'd12}) begin nerr++; $display("FAIL b2b_accept: got %h want %h", {done, busy, lo}, {2'b01, 32'd12}); end
        wait_done(lat);
        nchk++; if ({lat, lo} !== {32'd33, 32'd42}) begin nerr++; $display("FAIL b2b_result: got lat %0d lo %0d want 33 42", lat, lo); end
    endtask

    task automatic test_reset_mid;
        int seen = 0;
        go(3'b000, 32'd5, 32'd6);
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0; #1;
        nchk++; if ({busy, done, hi, lo} !== 66'h0) begin nerr++; $display("FAIL reset_mid: got %h want 0", {busy, done, hi, lo}); end
        @(negedge clk); rst_n = 1'b1;
        repeat (40) begin @(posedge clk); #1; seen += done; end
        nchk++; if (seen !== 0) begin nerr++; $display("FAIL reset_mid_nodone: got %0d want 0", seen); end
    endtask

    task automatic test_w8;
        int lat = -1;
        start8 = 1'b1; op8 = 3'b000; a8 = 8'hFF; b8 = 8'hFF;
        @(posedge clk); #1;
        start8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
        for (int n = 1; n <= 50; n++) begin
            @(posedge clk); #1;
            if (done8) begin lat = n; break; end
        end
        nchk++; if (lat !== 9) begin nerr++; $display("FAIL w8_latency: got %0d want 9", lat); end
        nchk++; if ({hi8, lo8} !== 16'hFE01) begin nerr++; $display("FAIL w8_hilo: got %h want fe01", {hi8, lo8}); end
    endtask

    initial begin
        test_reset;
        test_multu;
        test_mult;
        test_div;
        test_dbz;
        test_back_to_back;
        test_reset_mid;
        test_w8;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
        $finish;
    end
endmodule
